rsa_modexp_engine: RTL and testbench

//  Multi-cycle RSA modular-exponentiation core: result = base^exp mod n, all operands KEY_WIDTH bits.

---
 rtl/rsa_modexp_engine.sv | 207 ++++++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: multi-cycle modular exponentiation, result = base^exp mod n.
// Word-serial operand load (MS word first), bit-serial left-to-right
// square-and-multiply built on an interleaved shift-add modular multiplier,
// word-serial result unload with out_ready backpressure.
// Optional feature macro: RSA_OPERAND_CHECK_EN adds the err output and rejects
// starts whose operands violate n>=2 and base<n.
module rsa_modexp_engine #(
    parameter int KEY_WIDTH  = 256,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic [1:0]            select,
    input  logic                  start,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  busy,
`ifdef RSA_OPERAND_CHECK_EN
    output logic                  done,
    output logic                  err
`else
    output logic                  done
`endif
);
    localparam int NWORDS = KEY_WIDTH / WORD_WIDTH;
    localparam int CW     = $clog2(KEY_WIDTH + 1);
    localparam int BW     = $clog2(KEY_WIDTH);
    localparam int PW     = $clog2(NWORDS + 1);
    localparam int AW     = KEY_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_UNLOAD} state_t;

    state_t                state_q, state_d;
    logic [KEY_WIDTH-1:0]  base_q, exp_q, mod_q;
    logic [2:0]            loaded_q;          // {base, exp, mod}
    logic [PW-1:0]         ptr_q;
    logic [1:0]            last_sel_q;
    logic                  load_fresh_q;
    logic [KEY_WIDTH-1:0]  r_q;               // running result R
    logic [KEY_WIDTH-1:0]  mplr_q;            // multiplier bits, consumed MSB first
    logic [AW-1:0]         acc_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_idx_q;
    logic [PW-1:0]         wptr_q;
    logic                  done_q;

    logic                  start_hit, start_go, load_hit, fire;
    logic                  operands_ok, op_last, bit_last, word_last;
    logic [PW-1:0]         p_eff;
    logic [KEY_WIDTH-1:0]  cur_val, load_val;
    logic                  load_keep;
    logic [AW-1:0]         n_ext, a_op, sum, red1, red2;

`ifdef RSA_OPERAND_CHECK_EN
    assign operands_ok = (mod_q >= KEY_WIDTH'(2)) && (base_q < mod_q);
`else
    assign operands_ok = 1'b1;
`endif

    assign start_hit = en && (state_q == S_IDLE) && start;
    assign start_go  = start_hit && (&loaded_q) && operands_ok;
    assign load_hit  = en && (state_q == S_IDLE) && valid_in && !start && (select != 2'b00);
    assign fire      = en && (state_q == S_UNLOAD) && out_ready;
    assign op_last   = (cnt_q == CW'(KEY_WIDTH));
    assign bit_last  = (bit_idx_q == '0);
    assign word_last = (wptr_q == PW'(NWORDS - 1));

    // Operand load: pick the word slot and build the updated target register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        p_eff   = (load_fresh_q || (select != last_sel_q)) ? '0 : ptr_q;
        cur_val = mod_q;
        case (select)
            2'b11:   cur_val = base_q;
            2'b10:   cur_val = exp_q;
            default: cur_val = mod_q;
        endcase
        load_val = (p_eff == '0) ? '0 : cur_val;
        for (int w = 0; w < NWORDS; w++) begin
            if (p_eff == PW'(w)) load_val[KEY_WIDTH-1-w*WORD_WIDTH -: WORD_WIDTH] = data_in;
        end
        load_keep = (p_eff < PW'(NWORDS));
    end

    // One modmul iteration: acc = 2*acc (+a), then at most two subtractions of n.
    always_comb begin
        n_ext = {2'b00, mod_q};
        a_op  = (state_q == S_SQR) ? {2'b00, r_q} : {2'b00, base_q};
        sum   = (acc_q << 1) + (mplr_q[KEY_WIDTH-1] ? a_op : '0);
        red1  = (sum  >= n_ext) ? sum  - n_ext : sum;
        red2  = (red1 >= n_ext) ? red1 - n_ext : red1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: SQR per exponent bit, MUL only for set bits, then unload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_go) state_d = S_SQR;
            S_SQR:    if (en && op_last) begin
                          if (exp_q[bit_idx_q]) state_d = S_MUL;
                          else if (bit_last)    state_d = S_UNLOAD;
                          else                  state_d = S_SQR;
                      end
            S_MUL:    if (en && op_last) state_d = bit_last ? S_UNLOAD : S_SQR;
            S_UNLOAD: if (fire && word_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: operand registers, modmul accumulator, bit and word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q       <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
            loaded_q     <= '0;
            ptr_q        <= '0;
            last_sel_q   <= '0;
            load_fresh_q <= 1'b1;
            r_q          <= '0;
            mplr_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            wptr_q       <= '0;
            done_q       <= 1'b0;
        end else if (en) begin
            done_q <= 1'b0;
            if (load_hit) begin
                if (load_keep) begin
                    case (select)
                        2'b11:   base_q <= load_val;
                        2'b10:   exp_q  <= load_val;
                        default: mod_q  <= load_val;
                    endcase
                    loaded_q[select - 2'd1] <= 1'b1;
                    ptr_q <= p_eff + 1'b1;
                end
                last_sel_q   <= select;
                load_fresh_q <= 1'b0;
            end
            if (start_hit) load_fresh_q <= 1'b1;
            if (start_go) begin
                r_q       <= KEY_WIDTH'(1);
                mplr_q    <= KEY_WIDTH'(1);
                acc_q     <= '0;
                cnt_q     <= '0;
                bit_idx_q <= BW'(KEY_WIDTH - 1);
                wptr_q    <= '0;
            end
            if (state_q == S_SQR || state_q == S_MUL) begin
                if (op_last) begin
                    r_q    <= acc_q[KEY_WIDTH-1:0];
                    mplr_q <= acc_q[KEY_WIDTH-1:0];
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    if ((state_q == S_MUL || !exp_q[bit_idx_q]) && !bit_last)
                        bit_idx_q <= bit_idx_q - 1'b1;
                end else begin
                    acc_q  <= red2;
                    mplr_q <= mplr_q << 1;
                    cnt_q  <= cnt_q + 1'b1;
                end
            end
            if (fire) begin
                if (word_last) done_q <= 1'b1;
                else           wptr_q <= wptr_q + 1'b1;
            end
        end
    end

`ifdef RSA_OPERAND_CHECK_EN
    // Rejected start: one-cycle err pulse, FSM stays idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     err <= 1'b0;
        else if (en) err <= start_hit && (&loaded_q) && !operands_ok;
    end
`endif

    // Unload outputs: current result word, zero while not valid.
    always_comb begin
        data_out = '0;
        if (state_q == S_UNLOAD) begin
            for (int w = 0; w < NWORDS; w++) begin
                if (wptr_q == PW'(w)) data_out = r_q[KEY_WIDTH-1-w*WORD_WIDTH -: WORD_WIDTH];
            end
        end
    end

    assign valid_out = (state_q == S_UNLOAD);
    assign last_out  = valid_out && word_last;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine at KEY_WIDTH=32, WORD_WIDTH=8.
// A plain-arithmetic modexp model supplies the expected result; a monitor
// compares every unload cycle against it. Directed tests cover the latency
// formula, backpressure, missing operands, reset mid-run and enable freeze.
module tb_rsa_modexp_engine;
    localparam int K  = 32;
    localparam int W  = 8;
    localparam int NW = K / W;

    logic         clk = 1'b0;
    logic         rst, en, valid_in, start, out_ready;
    logic [W-1:0] data_in;
    logic [1:0]   select;
    logic [W-1:0] data_out;
    logic         valid_out, last_out, busy, done;
`ifdef RSA_OPERAND_CHECK_EN
    logic         err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_words [NW];
    int           mon_idx = 0;
    bit           mon_on  = 1'b0;

    rsa_modexp_engine #(.KEY_WIDTH(K), .WORD_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .valid_in(valid_in),
        .select(select), .start(start), .out_ready(out_ready),
        .data_out(data_out), .valid_out(valid_out), .last_out(last_out),
        .busy(busy),
`ifdef RSA_OPERAND_CHECK_EN
        .done(done), .err(err)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: left-to-right square-and-multiply on plain integers.
    function automatic logic [31:0] model_modexp(input logic [31:0] b, input logic [31:0] e,
                                                 input logic [31:0] n);
        longint unsigned r = 1;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * b) % n;
        end
        return r[31:0];
    endfunction

    // Output monitor: each unload word against the model, zero outputs otherwise.
    always @(negedge clk) begin
        if (!rst && mon_on) begin
            if (valid_out) begin
                if (mon_idx < NW) begin
                    check("mon_word", data_out, exp_words[mon_idx]);
                    check("mon_last", last_out, mon_idx == NW - 1);
                end else begin
                    check("mon_extra_word", mon_idx, NW - 1);
                end
            end else begin
                check("mon_idle_data", data_out, 0);
                check("mon_idle_last", last_out, 0);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && en && valid_out && out_ready) mon_idx++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [1:0] sel, input logic [W-1:0] b);
        data_in = b; select = sel; valid_in = 1'b1;
        tick();
        valid_in = 1'b0; select = 2'b00; data_in = '0;
    endtask

    task automatic load_op(input logic [1:0] sel, input logic [31:0] v);
        for (int i = 0; i < NW; i++) send_word(sel, v[31-8*i -: 8]);
    endtask

    task automatic load_all(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
        load_op(2'b11, b);
        load_op(2'b10, e);
        load_op(2'b01, n);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        mon_idx = 0;
    endtask

    // Start, measure start->first valid latency, unload with optional stall and freeze.
    task automatic run(input string tag, input logic [31:0] expv, input int exp_lat,
                       input int stall_idx, input int freeze, output logic [31:0] res);
        int  cnt = 0;
        bit  got = 1'b0;
        logic [W-1:0] held;
        res = '0;
        for (int w = 0; w < NW; w++) exp_words[w] = expv[31-8*w -: 8];
        mon_idx   = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        while (cnt < 6000 && !got) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                start = 1'b0;
                check({tag, "_busy_after_start"}, busy, 1);
                if (freeze > 0) en = 1'b0;
            end
            if (freeze > 0 && cnt == freeze + 1) begin
                check({tag, "_busy_frozen"}, busy, 1);
                en = 1'b1;
            end
            if (valid_out) got = 1'b1;
        end
        check({tag, "_latency"}, cnt, exp_lat);
        if (got) begin
            for (int w = 0; w < NW; w++) begin
                check({tag, "_valid_word"}, valid_out, 1);
                if (w == stall_idx) begin
                    held = data_out;
                    out_ready = 1'b0;
                    repeat (3) begin
                        tick();
                        check({tag, "_stall_valid"}, valid_out, 1);
                        check({tag, "_stall_data"}, data_out, held);
                    end
                    out_ready = 1'b1;
                end
                res[31-8*w -: 8] = data_out;
                check({tag, "_last_flag"}, last_out, w == NW - 1);
                tick();
            end
            check({tag, "_result"}, res, expv);
            check({tag, "_done_pulse"}, done, 1);
            check({tag, "_busy_clear"}, busy, 0);
            check({tag, "_valid_clear"}, valid_out, 0);
            tick();
            check({tag, "_done_one_cycle"}, done, 0);
        end
    endtask

    initial begin
        logic [31:0] res;
        int          vcount;
        rst = 1'b1; en = 1'b1; valid_in = 1'b0; start = 1'b0; out_ready = 1'b0;
        data_in = '0; select = 2'b00;

        // Model pinned to hand-computed values.
        check("model_4_13_497", model_modexp(32'd4, 32'd13, 32'd497), 32'd445);
        check("model_exp0", model_modexp(32'd4, 32'd0, 32'd497), 32'd1);
        check("model_3_5_7", model_modexp(32'd3, 32'd5, 32'd7), 32'd5);

        // Reset state.
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid_out, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        check("rst_last", last_out, 0);
`ifdef RSA_OPERAND_CHECK_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // Test 1: 4^13 mod 497.
        load_all(32'h4, 32'hD, 32'h1F1);
        run("t1", model_modexp(32'h4, 32'hD, 32'h1F1), 33 * (32 + 3) + 1, -1, 0, res);
        check("t1_literal", res, 32'h000001BD);

        // Test 2: exponent zero, base/mod reused; 20-cycle enable freeze adds 20 cycles.
        load_op(2'b10, 32'h0);
        run("t2", model_modexp(32'h4, 32'h0, 32'h1F1), 33 * 32 + 1 + 20, -1, 20, res);
        check("t2_literal", res, 32'h00000001);

        // Test 3: test 1 with 3-cycle backpressure on word 1.
        load_op(2'b10, 32'hD);
        run("t3", model_modexp(32'h4, 32'hD, 32'h1F1), 33 * 35 + 1, 1, 0, res);
        check("t3_literal", res, 32'h000001BD);

        // Test 4: exponent never loaded -> start ignored.
        apply_reset();
        load_op(2'b11, 32'h4);
        load_op(2'b01, 32'h1F1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy", busy, 0);
        vcount = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (valid_out || busy) vcount++;
        end
        check("t4_no_activity", vcount, 0);

        // Test 5: reset 100 cycles into a run; operands must then be reloaded.
        apply_reset();
        load_all(32'h4, 32'hD, 32'h1F1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        check("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", valid_out, 0);
        check("t5_rst_done", done, 0);
        tick();
        rst = 1'b0;
        mon_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_start_ignored", busy, 0);
        // Base reload with a fifth word that must be dropped.
        load_op(2'b11, 32'h4);
        send_word(2'b11, 8'hFF);
        load_op(2'b10, 32'hD);
        load_op(2'b01, 32'h1F1);
        run("t5", model_modexp(32'h4, 32'hD, 32'h1F1), 33 * 35 + 1, -1, 0, res);
        check("t5_literal", res, 32'h000001BD);

`ifdef RSA_OPERAND_CHECK_EN
        // Test 6: base >= n rejected with a single err pulse.
        load_op(2'b11, 32'h258);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_err", err, 1);
        check("t6_busy", busy, 0);
        tick();
        check("t6_err_pulse", err, 0);
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid_out || busy) vcount++;
        end
        check("t6_no_output", vcount, 0);
        // n < 2 rejected.
        load_op(2'b11, 32'h0);
        load_op(2'b01, 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_err_small_n", err, 1);
        check("t6_busy_small_n", busy, 0);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
